// File: rtl/postcode_buffered_pkg.sv
// rtl/postcode_buffered_pkg.sv - shared state encoding, sync depth and timeout helper for the POST engine
package postcode_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P3,
    S_INPOLL,
    S_INBIT,
    S_IGNORE
  } post_state_e;

  // testreq synchroniser stages; testack qualifies on the last one
  localparam int ACK_DELAY = 3;

  function automatic int unsigned timeout_limit(input int unsigned base,
                                                input int unsigned mult,
                                                input logic        extended);
    return extended ? base * mult : base;
  endfunction

endpackage

// File: rtl/postcode_buffered_if.sv
// rtl/postcode_buffered_if.sv - host-side rx/tx valid/ready bundle for postcode_buffered
interface postcode_buffered_if #(
  parameter int DEPTH = 4
);
  logic [7:0]                   rx_data;
  logic                         rx_valid;
  logic                         rx_ready;
  logic [$clog2(DEPTH+1)-1:0]   rx_count;
  logic [7:0]                   tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic [$clog2(DEPTH+1)-1:0]   tx_count;

  modport master (
    input  rx_data, rx_valid, rx_count, tx_ready, tx_count,
    output rx_ready, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, rx_count, tx_ready, tx_count,
    input  rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/post_fifo.sv
// rtl/post_fifo.sv - synchronous first-word-fall-through FIFO, DEPTH a power of two
module post_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // head reads as zero while empty so the output is defined straight out of reset
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/postcode_buffered.sv
// rtl/postcode_buffered.sv - POST TESTREQ/TESTACK engine with rx/tx FIFOs; POSTCODE_STATS_EN builds the stat counters
module postcode_buffered
  import postcode_pkg::*;
#(
  parameter int REFCLK_FREQ     = 48000000,
  parameter int TIMER_MAX       = 480,
  parameter int POST_INPUT_MULT = 2,
  parameter int IGNORE_PULSES   = 4,
  parameter int DEPTH           = 4
) (
  input  logic               refclk,
  input  logic               reset,
  input  logic               testreq,
  output logic               testack,
  postcode_buffered_if.slave host,
  output logic [15:0]        stat_rx_bytes,
  output logic [15:0]        stat_tx_bytes,
  output logic [15:0]        stat_nacks
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMER_MAX * POST_INPUT_MULT + 1) + ((REFCLK_FREQ > 0) ? 0 : 1);

  localparam logic [2:0] IDLE   = 3'(S_IDLE);
  localparam logic [2:0] P1     = 3'(S_P1);
  localparam logic [2:0] P2     = 3'(S_P2);
  localparam logic [2:0] P3     = 3'(S_P3);
  localparam logic [2:0] INPOLL = 3'(S_INPOLL);
  localparam logic [2:0] INBIT  = 3'(S_INBIT);
  localparam logic [2:0] IGNORE = 3'(S_IGNORE);

  logic [ACK_DELAY-1:0] req_sync;
  logic                 rise;
  logic [TW-1:0]        timer;
  logic [TW-1:0]        limit;
  logic                 timeout;
  logic [2:0]           state;
  logic [2:0]           idx;
  logic [2:0]           rxbits;
  logic [3:0]           ign_cnt;
  logic                 ack_int;
  logic                 ext;
  logic [6:0]           rxshift;
  logic [7:0]           txshift;
  logic [7:0]           tx_dout;
  logic [7:0]           rx_din;
  logic [CW:0]          rx_need;
  logic                 rx_space, rx_push, rx_empty, rx_full;
  logic                 tx_poll, tx_pop, tx_empty, tx_full;

  assign rise    = req_sync[1] && !req_sync[2];
  assign limit   = TW'(timeout_limit(TIMER_MAX, POST_INPUT_MULT, ext));
  assign timeout = !req_sync[1] && (timer >= limit);
  assign testack = testreq & ack_int & req_sync[2];

  // pulse-3 ack reserves a slot, counting a byte already part-assembled
  assign rx_need  = {1'b0, host.rx_count} + {{CW{1'b0}}, (rxbits != 3'd0)};
  assign rx_space = !rx_full && (rx_need < (CW+1)'(DEPTH));
  assign rx_din   = {rxshift, (state == P1)};
  assign rx_push  = timeout && (state == P1 || state == P2) && (rxbits == 3'd7);

  assign tx_poll = (state == P3) || (state == INPOLL && !ack_int) ||
                   (state == IGNORE && ign_cnt == 4'(IGNORE_PULSES));
  assign tx_pop  = rise && tx_poll && !tx_empty;

  always_ff @(posedge refclk) begin
    if (reset) begin
      req_sync <= '0;
      timer    <= '0;
    end else begin
      req_sync <= {req_sync[ACK_DELAY-2:0], testreq};
      if (req_sync[1])        timer <= '0;
      else if (timer < limit) timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state   <= IDLE;
      ack_int <= 1'b0;
      ext     <= 1'b0;
      idx     <= '0;
      ign_cnt <= '0;
      rxbits  <= '0;
      rxshift <= '0;
      txshift <= '0;
    end else if (rise) begin
      if (tx_poll) begin
        ack_int <= !tx_empty;
        if (!tx_empty) txshift <= tx_dout;
        ext   <= 1'b0;
        state <= INPOLL;
      end else begin
        case (state)
          IDLE: begin ack_int <= 1'b1; state <= P1; end
          P1:   begin ack_int <= 1'b1; state <= P2; end
          P2: begin
            ack_int <= rx_space;
            rxbits  <= '0;
            rxshift <= '0;
            state   <= P3;
          end
          INPOLL: begin
            ack_int <= txshift[7];
            idx     <= 3'd6;
            state   <= INBIT;
          end
          INBIT: begin
            ack_int <= txshift[idx];
            if (idx == 3'd0) begin
              ext     <= 1'b1;
              ign_cnt <= '0;
              state   <= IGNORE;
            end else begin
              idx <= idx - 3'd1;
            end
          end
          IGNORE: begin
            ack_int <= 1'b0;
            ign_cnt <= ign_cnt + 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end else if (timeout) begin
      state <= IDLE;
      ext   <= 1'b0;
      if (state == P1 || state == P2) begin
        rxshift <= rx_din[6:0];
        rxbits  <= rxbits + 3'd1;
      end
    end
  end

  post_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(refclk), .reset(reset),
    .push(rx_push), .din(rx_din),
    .pop(host.rx_ready), .dout(host.rx_data),
    .full(rx_full), .empty(rx_empty), .count(host.rx_count)
  );

  post_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(refclk), .reset(reset),
    .push(host.tx_valid && host.tx_ready), .din(host.tx_data),
    .pop(tx_pop), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty), .count(host.tx_count)
  );

  assign host.rx_valid = !rx_empty;
  assign host.tx_ready = !tx_full && !reset;

`ifdef POSTCODE_STATS_EN
  logic poll_nack;
  assign poll_nack = rise && ((state == P2 && !rx_space) || (tx_poll && tx_empty));

  always_ff @(posedge refclk) begin
    if (reset) begin
      stat_rx_bytes <= '0;
      stat_tx_bytes <= '0;
      stat_nacks    <= '0;
    end else begin
      if (rx_push)   stat_rx_bytes <= stat_rx_bytes + 16'd1;
      if (tx_pop)    stat_tx_bytes <= stat_tx_bytes + 16'd1;
      if (poll_nack) stat_nacks    <= stat_nacks + 16'd1;
    end
  end
`else
  assign stat_rx_bytes = '0;
  assign stat_tx_bytes = '0;
  assign stat_nacks    = '0;
`endif
endmodule

// File: tb/tb_postcode_buffered.sv
// tb/tb_postcode_buffered.sv - directed self-checking bench for postcode_buffered
module tb_postcode_buffered;
  localparam int TMAX  = 40;
  localparam int MULT  = 2;
  localparam int DEPTH = 4;
`ifdef POSTCODE_STATS_EN
  localparam int EXP_RX = 5, EXP_TX = 2, EXP_NAK = 5, EXP_RX_END = 1;
`else
  localparam int EXP_RX = 0, EXP_TX = 0, EXP_NAK = 0, EXP_RX_END = 0;
`endif

  logic        refclk = 1'b0;
  logic        reset = 1'b1;
  logic        testreq = 1'b0;
  logic        testack;
  logic [15:0] stat_rx_bytes, stat_tx_bytes, stat_nacks;
  logic        acks [16];
  int          n_checks = 0;
  int          n_fail = 0;

  postcode_buffered_if #(.DEPTH(DEPTH)) host_if ();

  postcode_buffered #(
    .TIMER_MAX(TMAX), .POST_INPUT_MULT(MULT), .IGNORE_PULSES(4), .DEPTH(DEPTH)
  ) dut (
    .refclk(refclk), .reset(reset), .testreq(testreq), .testack(testack),
    .host(host_if),
    .stat_rx_bytes(stat_rx_bytes), .stat_tx_bytes(stat_tx_bytes), .stat_nacks(stat_nacks)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      testreq = 1'b1;
      cycles(6);
      acks[i] = testack;
      testreq = 1'b0;
      cycles(6);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      pulses(b[i] ? 1 : 2);
      cycles(TMAX + 8);
    end
  endtask

  task automatic tx_push(input logic [7:0] b);
    host_if.tx_data  = b;
    host_if.tx_valid = 1'b1;
    cycles(1);
    host_if.tx_valid = 1'b0;
  endtask

  task automatic rx_pop();
    host_if.rx_ready = 1'b1;
    cycles(1);
    host_if.rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    host_if.rx_ready = 1'b0;
    host_if.tx_valid = 1'b0;
    host_if.tx_data  = 8'h00;

    reset = 1'b1;
    cycles(5);
    chk("rst_testack", testack, 0);
    chk("rst_rx_valid", host_if.rx_valid, 0);
    chk("rst_tx_ready", host_if.tx_ready, 0);
    chk("rst_rx_count", host_if.rx_count, 0);
    chk("rst_tx_count", host_if.tx_count, 0);
    chk("rst_rx_data", host_if.rx_data, 0);
    reset = 1'b0;
    cycles(1);
    chk("tx_ready_after_rst", host_if.tx_ready, 1);

    // OUTPUT of 0xA5 after a 3-pulse poll
    pulses(3);
    chk("poll_p1_ack", acks[0], 1);
    chk("poll_p2_ack", acks[1], 1);
    chk("poll_p3_ack", acks[2], 1);
    cycles(TMAX + 8);
    send_bits(8'hA5, 8);
    chk("a5_valid", host_if.rx_valid, 1);
    chk("a5_data", host_if.rx_data, 8'hA5);
    chk("a5_count", host_if.rx_count, 1);
    rx_pop();
    chk("a5_popped", host_if.rx_count, 0);

    // fill the rx FIFO, fifth poll must be refused
    for (int k = 0; k < 4; k++) begin
      pulses(3);
      chk("fill_poll_ack", acks[2], 1);
      cycles(TMAX + 8);
      b = 8'h10 + 8'(k);
      send_bits(b, 8);
    end
    chk("full_count", host_if.rx_count, 4);
    pulses(3);
    chk("full_poll_nack", acks[2], 0);
    cycles(TMAX + 8);
    chk("full_head", host_if.rx_data, 8'h10);
    rx_pop();
    pulses(3);
    chk("after_pop_poll_ack", acks[2], 1);
    cycles(TMAX + 8);
    for (int k = 1; k < 4; k++) begin
      b = 8'h10 + 8'(k);
      chk("drain_data", host_if.rx_data, b);
      rx_pop();
    end
    chk("drained_valid", host_if.rx_valid, 0);

    // INPUT of 0x3C
    tx_push(8'h3C);
    chk("tx_count_one", host_if.tx_count, 1);
    pulses(12);
    chk("in_p4_ack", acks[3], 1);
    for (int i = 0; i < 8; i++) b[7-i] = acks[4+i];
    chk("input_3c", b, 8'h3C);
    chk("tx_count_zero", host_if.tx_count, 0);
    cycles(2 * TMAX + 10);

    // repeated pulse-4 polls against an empty tx FIFO, then 0x81
    pulses(4);
    chk("empty_p4_nack", acks[3], 0);
    pulses(1);
    chk("repoll_nack_a", acks[0], 0);
    pulses(1);
    chk("repoll_nack_b", acks[0], 0);
    tx_push(8'h81);
    pulses(1);
    chk("repoll_ack", acks[0], 1);
    pulses(8);
    for (int i = 0; i < 8; i++) b[7-i] = acks[i];
    chk("input_81", b, 8'h81);
    cycles(TMAX + TMAX / 2 - 6);
    pulses(4);
    for (int i = 0; i < 4; i++) chk("ignored_ack", acks[i], 0);
    pulses(1);
    chk("post_ignore_repoll_nack", acks[0], 0);
    cycles(2 * TMAX + 10);
    pulses(1);
    chk("idle_again_ack", acks[0], 1);
    cycles(TMAX + 8);

    chk("stat_rx_bytes", stat_rx_bytes, EXP_RX);
    chk("stat_tx_bytes", stat_tx_bytes, EXP_TX);
    chk("stat_nacks", stat_nacks, EXP_NAK);

    // reset in the middle of an OUTPUT byte
    pulses(3);
    cycles(TMAX + 8);
    send_bits(8'hFF, 5);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(1);
    chk("midbyte_rst_count", host_if.rx_count, 0);
    chk("midbyte_rst_valid", host_if.rx_valid, 0);
    pulses(3);
    chk("post_rst_poll_ack", acks[2], 1);
    cycles(TMAX + 8);
    send_bits(8'h0F, 8);
    chk("byte_0f_data", host_if.rx_data, 8'h0F);
    chk("byte_0f_count", host_if.rx_count, 1);
    chk("stat_rx_after_rst", stat_rx_bytes, EXP_RX_END);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
